// File: rtl/seq_multiplier_32_if.sv
// seq_multiplier_32_if: start/operand/result bundle for the sequential multiplier.
// With MUL_SAT32_EN defined it also carries the saturated 32-bit result and overflow flag.
interface seq_multiplier_32_if #(parameter int WIDTH = 32);
    logic                 en_mul_pulse;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;
`ifdef MUL_SAT32_EN
    logic [WIDTH-1:0]     product_sat;
    logic                 overflow;
    modport master (output en_mul_pulse, multiplicand, multiplier,
                    input product, busy, done, product_sat, overflow);
    modport slave  (input en_mul_pulse, multiplicand, multiplier,
                    output product, busy, done, product_sat, overflow);
`else
    modport master (output en_mul_pulse, multiplicand, multiplier,
                    input product, busy, done);
    modport slave  (input en_mul_pulse, multiplicand, multiplier,
                    output product, busy, done);
`endif
endinterface

// File: rtl/seq_multiplier_32.sv
// seq_multiplier_32: unsigned shift-add multiplier, one multiplier bit per clock, fixed 33-cycle latency.
// MUL_SAT32_EN adds registered product_sat/overflow outputs updated together with product.
module seq_multiplier_32 #(parameter int WIDTH = 32) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    seq_multiplier_32_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_sh_q, mcand_sh_d;
    logic [WIDTH-1:0]     mplr_sh_q, mplr_sh_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;
`ifdef MUL_SAT32_EN
    logic [WIDTH-1:0]     product_sat_q, product_sat_d;
    logic                 overflow_q, overflow_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_sh_d = mcand_sh_q;
        mplr_sh_d  = mplr_sh_q;
        product_d  = product_q;
        done_d     = 1'b0;
`ifdef MUL_SAT32_EN
        product_sat_d = product_sat_q;
        overflow_d    = overflow_q;
`endif
        // A start pulse overrides everything, including the completion edge.
        if (bus.en_mul_pulse) begin
            state_d    = RUN;
            cnt_d      = '0;
            acc_d      = '0;
            mcand_sh_d = {{WIDTH{1'b0}}, bus.multiplicand};
            mplr_sh_d  = bus.multiplier;
        end else begin
            case (state_q)
                RUN: begin
                    if (cnt_q < 6'(WIDTH)) begin
                        acc_d      = mplr_sh_q[0] ? acc_q + mcand_sh_q : acc_q;
                        mcand_sh_d = mcand_sh_q << 1;
                        mplr_sh_d  = mplr_sh_q >> 1;
                        cnt_d      = cnt_q + 6'd1;
                    end else begin
                        product_d = acc_q;
                        done_d    = 1'b1;
                        state_d   = DONE;
`ifdef MUL_SAT32_EN
                        overflow_d    = |acc_q[2*WIDTH-1:WIDTH];
                        product_sat_d = overflow_d ? '1 : acc_q[WIDTH-1:0];
`endif
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_sh_q <= '0;
            mplr_sh_q  <= '0;
            product_q  <= '0;
            done_q     <= 1'b0;
`ifdef MUL_SAT32_EN
            product_sat_q <= '0;
            overflow_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_sh_q <= mcand_sh_d;
            mplr_sh_q  <= mplr_sh_d;
            product_q  <= product_d;
            done_q     <= done_d;
`ifdef MUL_SAT32_EN
            product_sat_q <= product_sat_d;
            overflow_q    <= overflow_d;
`endif
        end
    end

    assign bus.product = product_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q == RUN);
`ifdef MUL_SAT32_EN
    assign bus.product_sat = product_sat_q;
    assign bus.overflow    = overflow_q;
`endif
endmodule

// File: tb/tb_seq_multiplier_32.sv
// tb_seq_multiplier_32: vector table, random operands against a plain A*B model,
// and hand-written abort / reset / back-to-back sequences.
module tb_seq_multiplier_32;
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    seq_multiplier_32_if bus();
    seq_multiplier_32 dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Caller sits at a negedge; the next posedge is E0.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.en_mul_pulse = 1'b1;
        bus.multiplicand = a;
        bus.multiplier = b;
        @(negedge sys_clk);
        bus.en_mul_pulse = 1'b0;
    endtask

    // Observes k = 1..max_k cycles after E0, scrambling operands while running.
    task automatic watch(input int max_k, input bit stop, input logic [63:0] bad,
                         output int dones, output int first_k, output bit saw_bad,
                         output int busy_err);
        dones = 0;
        first_k = -1;
        saw_bad = 1'b0;
        busy_err = (bus.busy !== 1'b1) ? 1 : 0;
        for (int k = 1; k <= max_k; k++) begin
            bus.multiplicand = $urandom;
            bus.multiplier = $urandom;
            @(negedge sys_clk);
            if (bus.product === bad) saw_bad = 1'b1;
            if (k <= 33 && bus.busy !== (k < 33)) busy_err++;
            if (bus.done === 1'b1) begin
                dones++;
                if (first_k < 0) first_k = k;
                if (stop) break;
            end
        end
    endtask

    task automatic check_result(input string name, input logic [63:0] p);
        check({name, " product"}, bus.product, p);
`ifdef MUL_SAT32_EN
        check({name, " overflow"}, 64'(bus.overflow), 64'(|p[63:32]));
        check({name, " product_sat"}, 64'(bus.product_sat),
              64'((|p[63:32]) ? 32'hFFFF_FFFF : p[31:0]));
`endif
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] p);
        int dones, first_k, busy_err;
        bit saw_bad;
        start_op(a, b);
        watch(40, 1'b1, 64'h0123_4567_89AB_CDEF, dones, first_k, saw_bad, busy_err);
        check({name, " latency"}, 64'(first_k), 64'd33);
        check({name, " busy"}, 64'(busy_err), 64'd0);
        check_result(name, p);
        @(negedge sys_clk);
        check({name, " done width"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int dones, first_k, busy_err;
        bit saw_bad;
        logic [31:0] a, b;
        tbl[0] = '{32'd3, 32'd5, 64'd15};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        tbl[2] = '{32'd0, 32'h1234_5678, 64'd0};
        tbl[3] = '{32'h1234_5678, 32'd0, 64'd0};
        tbl[4] = '{32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
        tbl[5] = '{32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000};
        bus.en_mul_pulse = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        repeat (3) @(negedge sys_clk);
        check("reset product", bus.product, 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
`ifdef MUL_SAT32_EN
        check("reset overflow", 64'(bus.overflow), 64'd0);
        check("reset product_sat", 64'(bus.product_sat), 64'd0);
`endif
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("idle busy", 64'(bus.busy), 64'd0);

        foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].p);

        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            run_op($sformatf("rand%0d", i), a, b, 64'(a) * 64'(b));
        end

        // Restart at iteration 10 abandons 7x9.
        start_op(32'd7, 32'd9);
        watch(10, 1'b0, 64'd63, dones, first_k, saw_bad, busy_err);
        start_op(32'd2, 32'd3);
        watch(45, 1'b0, 64'd63, dones, first_k, saw_bad, busy_err);
        check("abort dones", 64'(dones), 64'd1);
        check("abort latency", 64'(first_k), 64'd33);
        check("abort saw 63", 64'(saw_bad), 64'd0);
        check_result("abort", 64'd6);

        // Start held two cycles: counts from the last high cycle and its operands.
        bus.en_mul_pulse = 1'b1;
        bus.multiplicand = 32'd4;
        bus.multiplier = 32'd5;
        @(negedge sys_clk);
        bus.multiplicand = 32'd6;
        bus.multiplier = 32'd7;
        @(negedge sys_clk);
        bus.en_mul_pulse = 1'b0;
        watch(45, 1'b0, 64'd20, dones, first_k, saw_bad, busy_err);
        check("held dones", 64'(dones), 64'd1);
        check("held latency", 64'(first_k), 64'd33);
        check_result("held", 64'd42);

        // Restart on the cycle done is high.
        start_op(32'd10, 32'd10);
        watch(40, 1'b1, 64'hFFFF, dones, first_k, saw_bad, busy_err);
        check("b2b first latency", 64'(first_k), 64'd33);
        check_result("b2b first", 64'd100);
        start_op(32'd1000, 32'd1000);
        watch(45, 1'b0, 64'hFFFF, dones, first_k, saw_bad, busy_err);
        check("b2b second dones", 64'(dones), 64'd1);
        check("b2b second latency", 64'(first_k), 64'd33);
        check_result("b2b second", 64'd1_000_000);

        // Reset at iteration 20: outputs clear asynchronously, nothing completes.
        start_op(32'd100, 32'd100);
        watch(20, 1'b0, 64'hFFFF, dones, first_k, saw_bad, busy_err);
        sys_rst_n = 1'b0;
        #1;
        check("async rst product", bus.product, 64'd0);
        check("async rst busy", 64'(bus.busy), 64'd0);
        check("async rst done", 64'(bus.done), 64'd0);
`ifdef MUL_SAT32_EN
        check("async rst overflow", 64'(bus.overflow), 64'd0);
`endif
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        watch(40, 1'b0, 64'd10000, dones, first_k, saw_bad, busy_err);
        check("post rst dones", 64'(dones), 64'd0);
        check("post rst product", bus.product, 64'd0);
        check("post rst saw 10000", 64'(saw_bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
